// File: rtl/not_gate_checker.sv
// rtl/not_gate_checker.sv - response checker for an inverter under test: settle, compare y_obs against ~x_obs, report errors
// Optional build macro NOT_CHECK_ABORT_ON_ERR_EN: end the run at the first mismatching sample.
module not_gate_checker #(
  parameter int WIDTH       = 1,
  parameter int NUM_SAMPLES = 16,
  parameter int SETTLE      = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x_obs,
  input  logic [WIDTH-1:0] y_obs,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_x
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(NUM_SAMPLES - 1);
  localparam logic [CNT_W-1:0] ERR_MAX     = '1;
  // A zero-length settle window skips straight to the first compare.
  localparam logic [1:0] S_RUN_FIRST = (SETTLE == 0) ? S_CHECK : S_SETTLE;

  generate
    if (NUM_SAMPLES < 1 || longint'(NUM_SAMPLES) > (64'd1 << CNT_W)) begin : g_bad_num_samples
      $error("not_gate_checker: NUM_SAMPLES must be in 1..2**CNT_W");
    end
    if (SETTLE < 0) begin : g_bad_settle
      $error("not_gate_checker: SETTLE must be >= 0");
    end
  endgenerate

  logic [1:0]       state;
  logic [SET_W-1:0] settle_cnt;
  logic [CNT_W-1:0] sample_idx;
  logic             mismatch;

  // Case inequality makes X/Z on either bus count as a failure in simulation.
  assign mismatch = (y_obs !== ~x_obs);

  assign busy = (state == S_SETTLE) || (state == S_CHECK);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      settle_cnt    <= '0;
      sample_idx    <= '0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_x   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state         <= S_RUN_FIRST;
            settle_cnt    <= '0;
            sample_idx    <= '0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_x   <= '0;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= S_CHECK;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          sample_idx <= sample_idx + 1'b1;
          if (mismatch) begin
            if (err_count != ERR_MAX) begin
              err_count <= err_count + 1'b1;
            end
            // The counter saturates and never returns to zero, so zero marks "no failure yet".
            if (err_count == '0) begin
              first_err_idx <= sample_idx;
              first_err_x   <= x_obs;
            end
          end
`ifdef NOT_CHECK_ABORT_ON_ERR_EN
          if (mismatch || (sample_idx == SAMPLE_LAST)) begin
            state <= S_DONE;
            pass  <= !mismatch;
          end
`else
          if (sample_idx == SAMPLE_LAST) begin
            state <= S_DONE;
            pass  <= (err_count == '0) && !mismatch;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_not_gate_checker.sv
// tb/tb_not_gate_checker.sv - self-checking bench for not_gate_checker against a sample-list reference model
module tb_not_gate_checker;

  localparam int W      = 1;
  localparam int NUM    = 16;
  localparam int SETTLE = 1;
  localparam int CW     = 8;
  localparam int CW1    = 4;
  localparam int MAX_CYC = 64;

  logic clk = 1'b0;
  logic rst, start;
  logic [W-1:0] x, y;
  logic busy, done, pass;
  logic [CW-1:0] err_count, first_err_idx;
  logic [W-1:0] first_err_x;
  logic busy1, done1, pass1;
  logic [CW1-1:0] err_count1, first_err_idx1;
  logic [W-1:0] first_err_x1;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] xs [MAX_CYC];
  logic [W-1:0] ys [MAX_CYC];
  int bn, da, e, fi, fx, n, e1, fi1, fx1, n1;
  bit ov;

  always #5 clk = ~clk;

  not_gate_checker #(.WIDTH(W), .NUM_SAMPLES(NUM), .SETTLE(SETTLE), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .x_obs(x), .y_obs(y),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_idx(first_err_idx), .first_err_x(first_err_x)
  );

  not_gate_checker #(.WIDTH(W), .NUM_SAMPLES(NUM), .SETTLE(SETTLE), .CNT_W(CW1)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .x_obs(x), .y_obs(y),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1),
    .first_err_idx(first_err_idx1), .first_err_x(first_err_x1)
  );

  // Reference: walk the recorded per-sample values and apply the checking rules directly.
  function automatic void model(input int cap, output int ec, output int fidx, output int fxv, output int ns);
    ec = 0; fidx = 0; fxv = 0; ns = NUM;
    for (int s = 0; s < NUM; s++) begin
      int j;
      j = s + 1 + SETTLE;
      if (ys[j] !== ~xs[j]) begin
        if (ec == 0) begin
          fidx = s;
          fxv = int'(xs[j]);
        end
        if (ec < cap) ec++;
`ifdef NOT_CHECK_ABORT_ON_ERR_EN
        ns = s + 1;
        break;
`endif
      end
    end
  endfunction

  // Mode: 0 good inverter, 1 stuck-at-0 output, 2 single glitch, 3 y follows x, 4 random y.
  task automatic drive_run(input int mode, input int glitch, input bit spam, input int rst_cyc,
                           output int busy_n, output int done_at, output bit overlap);
    int s;
    busy_n = 0; done_at = -1; overlap = 0;
    for (int j = 0; j < MAX_CYC; j++) begin
      @(negedge clk);
      s = j - 1 - SETTLE;
      start = (j == 0) || (spam && j >= 2 && j < 8);
      rst = (j == rst_cyc);
      case (mode)
        0: begin x = W'($urandom); y = ~x; end
        1: begin x = W'(s & 1); y = '0; end
        2: begin x = (s == glitch) ? '1 : W'($urandom); y = (s == glitch) ? x : ~x; end
        3: begin x = W'($urandom); y = x; end
        default: begin x = W'($urandom); y = W'($urandom); end
      endcase
      xs[j] = x;
      ys[j] = y;
      @(posedge clk);
      #1;
      if (busy && done) overlap = 1;
      if (busy) busy_n++;
      if (rst) begin
        rst = 0; start = 0;
        return;
      end
      if (done) begin
        done_at = j + 1;
        start = 0;
        return;
      end
    end
    start = 0;
  endtask

  task automatic test_reset;
    rst = 1; start = 0; x = '0; y = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, pass, err_count, first_err_idx, first_err_x} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%0b done=%0b pass=%0b err=%0d idx=%0d x=%0h want all zero",
               busy, done, pass, err_count, first_err_idx, first_err_x);
    end
    checks++;
    if ({busy1, done1, pass1, err_count1, first_err_idx1, first_err_x1} !== '0) begin
      errors++;
      $display("FAIL reset_state_sat: got busy=%0b done=%0b pass=%0b err=%0d want all zero",
               busy1, done1, pass1, err_count1);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_correct_inverter;
    drive_run(0, -1, 0, -1, bn, da, ov);
    model((1 << CW) - 1, e, fi, fx, n);
    checks++;
    if ({err_count, first_err_idx, first_err_x, pass} !== {CW'(e), CW'(fi), W'(fx), e == 0}) begin
      errors++;
      $display("FAIL correct_result: got err=%0d idx=%0d x=%0h pass=%0b want err=%0d idx=%0d x=%0h pass=%0b",
               err_count, first_err_idx, first_err_x, pass, e, fi, fx, e == 0);
    end
    checks++;
    if (bn !== 17 || da !== 18 || ov) begin
      errors++;
      $display("FAIL correct_timing: got busy_cycles=%0d done_at=%0d overlap=%0b want 17 18 0", bn, da, ov);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({done, busy, pass, err_count} !== {1'b1, 1'b0, 1'b1, CW'(0)}) begin
      errors++;
      $display("FAIL correct_hold: got done=%0b busy=%0b pass=%0b err=%0d want 1 0 1 0", done, busy, pass, err_count);
    end
  endtask

  task automatic test_stuck_at_zero;
    drive_run(1, -1, 0, -1, bn, da, ov);
    model((1 << CW) - 1, e, fi, fx, n);
    checks++;
    if ({err_count, first_err_idx, first_err_x, pass} !== {CW'(e), CW'(fi), W'(fx), e == 0}) begin
      errors++;
      $display("FAIL stuck_result: got err=%0d idx=%0d x=%0h pass=%0b want err=%0d idx=%0d x=%0h pass=%0b",
               err_count, first_err_idx, first_err_x, pass, e, fi, fx, e == 0);
    end
    checks++;
    if (bn !== SETTLE + n || da !== SETTLE + n + 1 || ov) begin
      errors++;
      $display("FAIL stuck_timing: got busy_cycles=%0d done_at=%0d overlap=%0b want %0d %0d 0",
               bn, da, ov, SETTLE + n, SETTLE + n + 1);
    end
  endtask

  task automatic test_single_glitch;
    drive_run(2, 5, 0, -1, bn, da, ov);
    model((1 << CW) - 1, e, fi, fx, n);
    checks++;
    if ({err_count, first_err_idx, first_err_x, pass} !== {CW'(e), CW'(fi), W'(fx), e == 0}) begin
      errors++;
      $display("FAIL glitch_result: got err=%0d idx=%0d x=%0h pass=%0b want err=%0d idx=%0d x=%0h pass=%0b",
               err_count, first_err_idx, first_err_x, pass, e, fi, fx, e == 0);
    end
    checks++;
    if (bn !== SETTLE + n || da !== SETTLE + n + 1 || ov) begin
      errors++;
      $display("FAIL glitch_timing: got busy_cycles=%0d done_at=%0d overlap=%0b want %0d %0d 0",
               bn, da, ov, SETTLE + n, SETTLE + n + 1);
    end
  endtask

  task automatic test_reset_mid_run;
    drive_run(3, -1, 0, 1 + SETTLE + 7, bn, da, ov);
    checks++;
    if ({busy, done, pass, err_count, first_err_idx, first_err_x} !== '0) begin
      errors++;
      $display("FAIL midrun_reset: got busy=%0b done=%0b pass=%0b err=%0d idx=%0d x=%0h want all zero",
               busy, done, pass, err_count, first_err_idx, first_err_x);
    end
    drive_run(1, -1, 0, -1, bn, da, ov);
    model((1 << CW) - 1, e, fi, fx, n);
    checks++;
    if ({err_count, first_err_idx, first_err_x, pass} !== {CW'(e), CW'(fi), W'(fx), e == 0}) begin
      errors++;
      $display("FAIL midrun_rerun: got err=%0d idx=%0d x=%0h pass=%0b want err=%0d idx=%0d x=%0h pass=%0b",
               err_count, first_err_idx, first_err_x, pass, e, fi, fx, e == 0);
    end
    checks++;
    if (bn !== SETTLE + n || da !== SETTLE + n + 1 || ov) begin
      errors++;
      $display("FAIL midrun_timing: got busy_cycles=%0d done_at=%0d want %0d %0d", bn, da, SETTLE + n, SETTLE + n + 1);
    end
  endtask

  task automatic test_saturation;
    drive_run(3, -1, 0, -1, bn, da, ov);
    model((1 << CW) - 1, e, fi, fx, n);
    model((1 << CW1) - 1, e1, fi1, fx1, n1);
    checks++;
    if ({err_count, first_err_idx, first_err_x, pass} !== {CW'(e), CW'(fi), W'(fx), e == 0}) begin
      errors++;
      $display("FAIL sat_wide: got err=%0d idx=%0d x=%0h pass=%0b want err=%0d idx=%0d x=%0h pass=%0b",
               err_count, first_err_idx, first_err_x, pass, e, fi, fx, e == 0);
    end
    checks++;
    if ({err_count1, first_err_idx1, first_err_x1, pass1, done1} !== {CW1'(e1), CW1'(fi1), W'(fx1), e1 == 0, 1'b1}) begin
      errors++;
      $display("FAIL sat_narrow: got err=%0d idx=%0d x=%0h pass=%0b done=%0b want err=%0d idx=%0d x=%0h pass=%0b done=1",
               err_count1, first_err_idx1, first_err_x1, pass1, done1, e1, fi1, fx1, e1 == 0);
    end
  endtask

  task automatic test_restart_and_ignored_start;
    drive_run(1, -1, 0, -1, bn, da, ov);
    drive_run(0, -1, 1, -1, bn, da, ov);
    model((1 << CW) - 1, e, fi, fx, n);
    checks++;
    if ({err_count, first_err_idx, first_err_x, pass} !== {CW'(e), CW'(fi), W'(fx), e == 0}) begin
      errors++;
      $display("FAIL restart_result: got err=%0d idx=%0d x=%0h pass=%0b want err=%0d idx=%0d x=%0h pass=%0b",
               err_count, first_err_idx, first_err_x, pass, e, fi, fx, e == 0);
    end
    checks++;
    if (bn !== 17 || da !== 18 || ov) begin
      errors++;
      $display("FAIL restart_timing: got busy_cycles=%0d done_at=%0d overlap=%0b want 17 18 0", bn, da, ov);
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 6; k++) begin
      drive_run(4, -1, k[0], -1, bn, da, ov);
      model((1 << CW) - 1, e, fi, fx, n);
      model((1 << CW1) - 1, e1, fi1, fx1, n1);
      checks++;
      if ({err_count, first_err_idx, first_err_x, pass} !== {CW'(e), CW'(fi), W'(fx), e == 0}) begin
        errors++;
        $display("FAIL random_result[%0d]: got err=%0d idx=%0d x=%0h pass=%0b want err=%0d idx=%0d x=%0h pass=%0b",
                 k, err_count, first_err_idx, first_err_x, pass, e, fi, fx, e == 0);
      end
      checks++;
      if (err_count1 !== CW1'(e1) || first_err_idx1 !== CW1'(fi1)) begin
        errors++;
        $display("FAIL random_narrow[%0d]: got err=%0d idx=%0d want err=%0d idx=%0d",
                 k, err_count1, first_err_idx1, e1, fi1);
      end
      checks++;
      if (bn !== SETTLE + n || da !== SETTLE + n + 1 || ov) begin
        errors++;
        $display("FAIL random_timing[%0d]: got busy_cycles=%0d done_at=%0d overlap=%0b want %0d %0d 0",
                 k, bn, da, ov, SETTLE + n, SETTLE + n + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_correct_inverter();
    test_stuck_at_zero();
    test_single_glitch();
    test_reset_mid_run();
    test_saturation();
    test_restart_and_ignored_start();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/not_gate_checker.md
Name: not_gate_checker

Overview:
- Synthesizable response checker for an inverter under test. It observes the gate input and output and judges them, the counterpart of a stimulus driver.
- After a start pulse it waits a settle window, then samples NUM_SAMPLES consecutive cycles.
- Each sample checks y_obs == ~x_obs bitwise, counts mismatches, and captures the first failure.
- Sits beside any NOT gate instance in a bench or on-chip BIST wrapper; results stay readable until the next start.

Parameters:
WIDTH, 1, bit width of observed input/output buses
NUM_SAMPLES, 16, number of cycles compared per run (>=1)
SETTLE, 1, cycles ignored after start before first compare (>=0)
CNT_W, 8, width of error counter and sample index

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  begin a run; sampled only in IDLE or DONE
x_obs  input  WIDTH  observed gate input
y_obs  input  WIDTH  observed gate output
busy  output  1  high in SETTLE or CHECK
done  output  1  high in DONE
pass  output  1  valid when done; 1 = zero mismatches
err_count  output  CNT_W  mismatching samples this run, saturating
first_err_idx  output  CNT_W  sample index (0-based) of first mismatch
first_err_x  output  WIDTH  x_obs value at first mismatch

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; busy=0, done=0, pass=0, err_count=0, first_err_idx=0, first_err_x=0, internal counters 0. Reset wins over every other event, including mid-run; the run is aborted with no result.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE: start=1 -> clear err_count/first_err_*/pass, go SETTLE (or CHECK directly if SETTLE==0).
- SETTLE: count SETTLE cycles, then go CHECK; inputs ignored; start ignored.
- CHECK: one compare per cycle. Sample i registers mismatch = |(y_obs ^ ~x_obs).
  - On mismatch: err_count+1, saturating at 2^CNT_W-1.
  - If it is the first mismatch, latch first_err_idx=i and first_err_x=x_obs.
  - After sample NUM_SAMPLES-1, go DONE; start ignored while busy.
- DONE: done=1, pass=(err_count==0). Outputs hold. start=1 -> same action as in IDLE (restart), done drops next cycle.
- Timing:
  - start at edge N -> busy=1 from N+1.
  - First compare at edge N+1+SETTLE.
  - done=1 one cycle after the last compare edge.
  - Total start-to-done = SETTLE+NUM_SAMPLES+1 cycles.
- busy and done are never high together. Outputs are registered only; no combinational path from inputs to outputs.
- X/Z on inputs counts as mismatch in simulation (use !== semantics in the compare); synthesis treats it as ordinary logic.
- Sample index counter is CNT_W bits; NUM_SAMPLES must be <= 2^CNT_W (elaboration-time check, $error if violated).

Optional Feature:
- Macro: NOT_CHECK_ABORT_ON_ERR_EN.
- Defined: the first mismatch in CHECK latches first_err_* and err_count=1, and moves to DONE on the next edge with pass=0. Remaining samples are skipped.
- Undefined: all NUM_SAMPLES are always compared; err_count reflects the total.

Test Plan:
1. Correct inverter (y=~x), WIDTH=1, NUM_SAMPLES=16, SETTLE=1, x toggling every cycle, start pulse -> busy for 17 cycles, done=1 at cycle 18, pass=1, err_count=0.
2. Stuck-at-0 output (y=0), x=0,1,0,1,... from sample 0 -> mismatches on every x=0 sample. Result: err_count=8, first_err_idx=0, first_err_x=0, pass=0.
3. Single glitch: y forced to x at sample index 5 only, x=1 there -> err_count=1, first_err_idx=5, first_err_x=1. With NOT_CHECK_ABORT_ON_ERR_EN: done asserts 1 cycle after sample 5.
4. Reset mid-run: assert rst at sample 7 -> next cycle all outputs 0 and state IDLE. A new start then runs a full 16-sample check with fresh counts.
5. Saturation: CNT_W=4, NUM_SAMPLES=16, y=x always -> err_count=15, not 0. pass=0.
6. Restart from DONE, plus start pulses during busy -> pulses during busy are ignored. start in DONE clears previous results and reruns with identical timing to scenario 1.
